wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- 4-entry write-back queue in front of a register file.
//
// A memory result and an ALU result can be offered in the same cycle. When
// both are accepted, the memory result is queued ahead of the ALU result.
// The head entry drives the register-file write port for as long as the
// queue is non-empty, and it retires on every clock edge.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   mem_*      memory/long-latency result offer (valid, rd, data)
//   alu_*      ALU result offer (valid, rd, data)
//   in_ready   both sources may present (occupancy <= 2)
//   WE3/A3/WD3 register-file write port, driven from the head entry
//   q_addr     hazard query address
//   q_pend     a queued write to q_addr exists
//   q_hit      bypass valid for q_addr
//   q_data     bypass data (youngest matching entry)
//   count      occupancy, 0..4
//   ovf_err    sticky: an offer arrived while in_ready was low
//
// Build option
//   WB_BYPASS_EN  defined: q_hit/q_data carry bypass information.
//                 undefined: q_hit = 0 and q_data = 0, and no data mux is built.
// ---------------------------------------------------------------------------
module wb_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        in_ready,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  input  logic [4:0]  q_addr,
  output logic        q_pend,
  output logic        q_hit,
  output logic [31:0] q_data,
  output logic [2:0]  count,
  output logic        ovf_err
);

  logic [4:0]  r_rd   [4];
  logic [31:0] r_data [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;

  logic        w_acc_mem;
  logic        w_acc_alu;
  logic        w_retire;
  logic        w_bad_offer;
  logic [1:0]  w_n_acc;
  logic [1:0]  w_alu_slot;
  logic        w_pend;
  logic [1:0]  w_idx;
`ifdef WB_BYPASS_EN
  logic [31:0] w_byp_data;
`endif

  // Acceptance, retirement and slot selection for the current edge
  always_comb begin
    in_ready    = (r_count <= 3'd2);
    w_acc_mem   = mem_valid & in_ready & (mem_rd != 5'd0);
    w_acc_alu   = alu_valid & in_ready & (alu_rd != 5'd0);
    w_retire    = (r_count != 3'd0);
    w_n_acc     = {1'b0, w_acc_mem} + {1'b0, w_acc_alu};
    // ALU entry sits behind the mem entry when both are accepted together
    w_alu_slot  = w_acc_mem ? (r_wr_ptr + 2'd1) : r_wr_ptr;
    // x0 writes are discarded silently and never count as overflow
    w_bad_offer = ~in_ready & ((mem_valid & (mem_rd != 5'd0)) |
                               (alu_valid & (alu_rd != 5'd0)));
  end

  // Queue control state: pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_acc;
      r_rd_ptr <= r_rd_ptr + {1'b0, w_retire};
      r_count  <= r_count + {1'b0, w_n_acc} - {2'b0, w_retire};
      r_ovf    <= r_ovf | w_bad_offer;
    end
  end

  // Entry storage; contents are meaningless while a slot is invalid
  always_ff @(posedge clk) begin
    if (w_acc_mem) begin
      r_rd[r_wr_ptr]   <= mem_rd;
      r_data[r_wr_ptr] <= mem_data;
    end
    if (w_acc_alu) begin
      r_rd[w_alu_slot]   <= alu_rd;
      r_data[w_alu_slot] <= alu_data;
    end
  end

  // Register-file write port driven by the head entry
  always_comb begin
    WE3     = w_retire;
    count   = r_count;
    ovf_err = r_ovf;
    if (w_retire) begin
      A3  = r_rd[r_rd_ptr];
      WD3 = r_data[r_rd_ptr];
    end else begin
      A3  = 5'd0;
      WD3 = 32'd0;
    end
  end

  // Hazard lookup, scanning from oldest to youngest so the last hit is the youngest
  always_comb begin
    w_pend = 1'b0;
    w_idx  = 2'd0;
`ifdef WB_BYPASS_EN
    w_byp_data = 32'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rd_ptr + i[1:0];
      if ((3'(i) < r_count) && (r_rd[w_idx] == q_addr) && (q_addr != 5'd0)) begin
        w_pend = 1'b1;
`ifdef WB_BYPASS_EN
        w_byp_data = r_data[w_idx];
`endif
      end else begin
        w_pend = w_pend;
      end
    end
  end

  // Query outputs
  always_comb begin
    q_pend = w_pend;
`ifdef WB_BYPASS_EN
    q_hit  = w_pend;
    q_data = w_byp_data;
`else
    q_hit  = 1'b0;
    q_data = 32'd0;
`endif
  end

endmodule
